// File: rtl/piece_sprite_engine_if.sv
// Pixel, slot-configuration and piece-ROM signals between the VGA side and the sprite engine.
interface piece_sprite_engine_if #(
  parameter int SPRITE_W  = 55,
  parameter int SPRITE_H  = 55,
  parameter int N_SPRITES = 4,
  parameter int N_TYPES   = 12,
  parameter int IDX_W     = 4
);
  localparam int SW     = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1;
  localparam int TW     = (N_TYPES > 1) ? $clog2(N_TYPES) : 1;
  localparam int ROM_AW = $clog2(N_TYPES * SPRITE_W * SPRITE_H);

  logic [9:0]        DrawX;
  logic [9:0]        DrawY;
  logic              frame_start;
  logic              cfg_we;
  logic [SW-1:0]     cfg_sel;
  logic [9:0]        cfg_x;
  logic [9:0]        cfg_y;
  logic [TW-1:0]     cfg_type;
  logic              cfg_en;
  logic              cfg_blink;
  logic [ROM_AW-1:0] rom_addr;
  logic [IDX_W-1:0]  rom_q;
  logic [IDX_W-1:0]  pix_idx;
  logic              pix_on;
  logic              blink_phase;

  modport master (
    output DrawX, DrawY, frame_start, cfg_we, cfg_sel, cfg_x, cfg_y,
           cfg_type, cfg_en, cfg_blink, rom_q,
    input  rom_addr, pix_idx, pix_on, blink_phase
  );

  modport slave (
    input  DrawX, DrawY, frame_start, cfg_we, cfg_sel, cfg_x, cfg_y,
           cfg_type, cfg_en, cfg_blink, rom_q,
    output rom_addr, pix_idx, pix_on, blink_phase
  );
endinterface

// File: rtl/piece_sprite_engine.sv
// Multi-slot chess-piece sprite renderer: double-buffered slots, priority hit test,
// shared registered piece ROM, transparency and blink, fixed 3-cycle pixel latency.
module piece_sprite_engine #(
  parameter int SPRITE_W        = 55,
  parameter int SPRITE_H        = 55,
  parameter int N_SPRITES       = 4,
  parameter int N_TYPES         = 12,
  parameter int IDX_W           = 4,
  parameter int TRANSPARENT_IDX = 0,
  parameter int BLINK_FRAMES    = 30
) (
  input logic                  vga_clk,
  input logic                  Reset,
  piece_sprite_engine_if.slave bus
);
  localparam int TW     = (N_TYPES > 1) ? $clog2(N_TYPES) : 1;
  localparam int ROM_AW = $clog2(N_TYPES * SPRITE_W * SPRITE_H);
  localparam int BW     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef struct packed {
    logic          en;
    logic          blink;
    logic [TW-1:0] kind;
    logic [9:0]    x;
    logic [9:0]    y;
  } slot_t;

  slot_t             pend [N_SPRITES];
  slot_t             act  [N_SPRITES];
  slot_t             ws;
  logic              hit;
  logic              sup;
  logic [9:0]        dx;
  logic [9:0]        dy;
  logic [ROM_AW-1:0] addr;
  logic              hit1, sup1, hit2, sup2;
  logic              opaque;
  logic [BW-1:0]     blink_ctr;

  // The active bank copies the pending bank as it stood before any same-cycle write.
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      for (int i = 0; i < N_SPRITES; i++) begin
        pend[i] <= '0;
        act[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N_SPRITES; i++) begin
        if (bus.frame_start)
          act[i] <= pend[i];
        if (bus.cfg_we && int'(bus.cfg_sel) == i)
          pend[i] <= '{en: bus.cfg_en, blink: bus.cfg_blink, kind: bus.cfg_type,
                       x: bus.cfg_x, y: bus.cfg_y};
      end
    end
  end

  // Scan from lowest priority upward so the lowest-indexed hitting slot wins.
  always_comb begin
    hit = 1'b0;
    ws  = '0;
    for (int i = N_SPRITES - 1; i >= 0; i--) begin
      if (act[i].en &&
          ({1'b0, bus.DrawX} >= {1'b0, act[i].x}) &&
          ({1'b0, bus.DrawX} <  {1'b0, act[i].x} + 11'(SPRITE_W)) &&
          ({1'b0, bus.DrawY} >= {1'b0, act[i].y}) &&
          ({1'b0, bus.DrawY} <  {1'b0, act[i].y} + 11'(SPRITE_H))) begin
        hit = 1'b1;
        ws  = act[i];
      end
    end
    dx   = bus.DrawX - ws.x;
    dy   = bus.DrawY - ws.y;
    addr = ROM_AW'(ws.kind) * ROM_AW'(SPRITE_W * SPRITE_H)
         + ROM_AW'(dy) * ROM_AW'(SPRITE_W) + ROM_AW'(dx);
    sup  = ws.en & ws.blink & bus.blink_phase;
  end

  assign opaque = hit2 & ~sup2 & (bus.rom_q != IDX_W'(TRANSPARENT_IDX));

  // Hit/suppress flags travel alongside the ROM read so they line up with rom_q.
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      bus.rom_addr <= '0;
      hit1         <= 1'b0;
      sup1         <= 1'b0;
      hit2         <= 1'b0;
      sup2         <= 1'b0;
      bus.pix_on   <= 1'b0;
      bus.pix_idx  <= '0;
    end else begin
      bus.rom_addr <= hit ? addr : '0;
      hit1         <= hit;
      sup1         <= sup;
      hit2         <= hit1;
      sup2         <= sup1;
      bus.pix_on   <= opaque;
      bus.pix_idx  <= opaque ? bus.rom_q : '0;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      blink_ctr       <= '0;
      bus.blink_phase <= 1'b0;
    end else if (bus.frame_start) begin
      if (blink_ctr == BW'(BLINK_FRAMES - 1)) begin
        blink_ctr       <= '0;
        bus.blink_phase <= ~bus.blink_phase;
      end else begin
        blink_ctr <= blink_ctr + BW'(1);
      end
    end
  end
endmodule
